// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: STAGES-deep pipelined carry-lookahead adder with valid/ready flow control.
// Optional macro CLA_PIPE_SUB_EN turns the sub input into a two's-complement subtract (a - b).
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG    = WIDTH / STAGES;
    localparam int GROUPS = SEG / 4;
    localparam int LAST   = STAGES - 1;

    // 4-bit lookahead group; returns {group generate, group propagate, sum[3:0]}
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p, p ^ c};
    endfunction

    // Adds segment k of x+y+ci into s; returns {carry out of the segment, s with segment k filled}
    function automatic logic [WIDTH:0] stage_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] s, input logic ci, input int k);
        logic [GROUPS-1:0] gg;
        logic [GROUPS-1:0] pg;
        logic [GROUPS:0]   gc;
        logic [3:0]        xg;
        logic [3:0]        yg;
        logic [5:0]        r;
        logic              pacc;
        logic [WIDTH-1:0]  so;
        so = s;
        for (int j = 0; j < GROUPS; j++) begin
            for (int i = 0; i < 4; i++) begin
                xg[i] = x[k*SEG + 4*j + i];
                yg[i] = y[k*SEG + 4*j + i];
            end
            r     = cla4(xg, yg, 1'b0);
            gg[j] = r[5];
            pg[j] = r[4];
        end
        // Second-level lookahead: each group carry is a flat sum of products over lower groups
        for (int j = 0; j <= GROUPS; j++) begin
            gc[j] = 1'b0;
            pacc  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                gc[j] = gc[j] | (pacc & gg[i]);
                pacc  = pacc & pg[i];
            end
            gc[j] = gc[j] | (pacc & ci);
        end
        for (int j = 0; j < GROUPS; j++) begin
            for (int i = 0; i < 4; i++) begin
                xg[i] = x[k*SEG + 4*j + i];
                yg[i] = y[k*SEG + 4*j + i];
            end
            r = cla4(xg, yg, gc[j]);
            for (int i = 0; i < 4; i++) begin
                so[k*SEG + 4*j + i] = r[i];
            end
        end
        return {gc[GROUPS], so};
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;

    logic [STAGES-1:0] ready_s;
    logic [STAGES-1:0] take_s;
    logic [STAGES-1:0] up_v_s;
    logic [STAGES-1:0] up_c_s;
    logic [WIDTH-1:0]  up_a_s [STAGES];
    logic [WIDTH-1:0]  up_b_s [STAGES];
    logic [WIDTH-1:0]  up_s_s [STAGES];
    logic [WIDTH:0]    add_s  [STAGES];
    logic [WIDTH-1:0]  b_eff_s;
    logic              c0_s;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff_s = sub ? ~b : b;
    assign c0_s    = sub ? 1'b1 : c_in;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_eff_s    = b;
    assign c0_s       = c_in;
`endif

    // Stage k is ready when it, or any stage after it, is empty, or the consumer takes the output
    always_comb begin
        ready_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            ready_s[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                ready_s[k] = ready_s[k] | ~valid_q[j];
            end
        end
    end

    assign in_ready = ready_s[0];

    // Per-stage segment add and next-state selection (load when ready, otherwise hold)
    always_comb begin
        up_v_s    = {STAGES{1'b0}};
        up_c_s    = {STAGES{1'b0}};
        up_v_s[0] = in_valid;
        up_c_s[0] = c0_s;
        up_a_s[0] = a;
        up_b_s[0] = b_eff_s;
        up_s_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            up_v_s[k] = valid_q[k-1];
            up_c_s[k] = c_q[k-1];
            up_a_s[k] = a_q[k-1];
            up_b_s[k] = b_q[k-1];
            up_s_s[k] = s_q[k-1];
        end
        take_s  = {STAGES{1'b0}};
        valid_d = valid_q;
        c_d     = c_q;
        for (int k = 0; k < STAGES; k++) begin
            add_s[k]  = stage_add(up_a_s[k], up_b_s[k], up_s_s[k], up_c_s[k], k);
            take_s[k] = ready_s[k] & up_v_s[k];
            if (ready_s[k]) begin
                valid_d[k] = up_v_s[k];
            end else begin
                valid_d[k] = valid_q[k];
            end
            if (take_s[k]) begin
                a_d[k] = up_a_s[k];
                b_d[k] = up_b_s[k];
                s_d[k] = add_s[k][WIDTH-1:0];
                c_d[k] = add_s[k][WIDTH];
            end else begin
                a_d[k] = a_q[k];
                b_d[k] = b_q[k];
                s_d[k] = s_q[k];
                c_d[k] = c_q[k];
            end
        end
        // Carry into the MSB is recovered as a^b^sum at that bit
        if (take_s[LAST]) begin
            ovf_d  = up_a_s[LAST][WIDTH-1] ^ up_b_s[LAST][WIDTH-1]
                   ^ add_s[LAST][WIDTH-1] ^ add_s[LAST][WIDTH];
            zero_d = (add_s[LAST][WIDTH-1:0] == {WIDTH{1'b0}});
        end else begin
            ovf_d  = ovf_q;
            zero_d = zero_q;
        end
    end

    // Pipeline and flag registers with synchronous reset that flushes every in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {STAGES{1'b0}};
            c_q     <= {STAGES{1'b0}};
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                s_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=32, STAGES=2): directed vectors pushed on issue,
// popped and compared by an independent output monitor.
module tb_cla_pipe_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a_s       = 32'h0;
    logic [31:0] b_s       = 32'h0;
    logic        c_in_s    = 1'b0;
    logic        sub_s     = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;

    typedef struct {
        logic [34:0] res;
        int          t;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [31:0] bb_a  [8] = '{32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'h7FFF_0000};
    logic [31:0] bb_b  [8] = '{32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_FFFF};
    logic        bb_c  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] bb_s  [8] = '{32'h0000_0000, 32'h0000_0001, 32'h2345_6789, 32'h0000_0000,
                               32'hFFFF_FFFF, 32'h0001_FFFF, 32'hDEAD_BEF0, 32'h8000_0000};
    logic        bb_co [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        bb_o  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        bb_z  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_s),
        .b         (b_s),
        .c_in      (c_in_s),
        .sub       (sub_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one operation, waits for acceptance and records its expected result.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb_i,
                         input logic [31:0] es, input logic ec, input logic eo, input logic ez,
                         input bit lat);
        exp_t e;
        int   guard;
        a_s      = av;
        b_s      = bv;
        c_in_s   = ci;
        sub_s    = sb_i;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_accept", in_ready, 1);
        if (in_ready) begin
            e.res = {es, ec, eo, ez};
            e.t   = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while ((sb.size() != 0 || in_valid || out_valid) && guard < 200);
        check("drain_pending", sb.size(), 0);
    endtask

    // Output monitor: every output transfer must match the oldest pending expectation
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: actual sum %08h with nothing pending", sum);
            end else begin
                mon_e = sb.pop_front();
                check("result", {sum, c_out, ovf, zero}, mon_e.res);
                if (mon_e.lat) check("latency", cyc - mon_e.t, STAGES);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_flags", {sum, c_out, ovf, zero}, 0);

        // Carry across the segment boundary, wrap to zero, signed overflow
        @(posedge clk);
        #1;
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_drain();

        // Eight back-to-back operations at full throughput
        for (int i = 0; i < 8; i++) begin
            issue(bb_a[i], bb_b[i], bb_c[i], 1'b0, bb_s[i], bb_co[i], bb_o[i], bb_z[i], 1'b1);
        end
        wait_drain();

        // Backpressure: two ops fill the pipe, the third must wait
        out_ready = 1'b0;
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            issue(32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        join_none
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_hold", {sum, c_out, ovf, zero}, {32'h0000_0003, 3'b000});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

`ifdef CLA_PIPE_SUB_EN
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        wait_drain();

        // Reset with two operations in flight discards both
        out_ready = 1'b0;
        issue(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_4444, 32'h0000_5555, 1'b0, 1'b0, 32'h0000_9999, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_outputs", {sum, c_out, ovf, zero}, 0);
        check("flush_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
